audio_dc_filter: RTL and testbench
==================================

Name: audio_dc_filter

Overview:
- Output stage directly downstream of the audio mixer.
- Accepts the mixer's saturated 16-bit signed sample stream over a valid/ready handshake.
- Removes DC offset with a first-order IIR high-pass (y = x - x_prev + a*y_prev, a = 1 - 2^-K_SHIFT), saturates the result and hands it to the DAC/HDMI audio serialiser.
- The multiply-free update runs in a small three-state FSM, one sample in flight at a time.

Parameters:
- DATA_W, 16, sample width in bits (signed) on input and output.
- K_SHIFT, 8, pole shift; a = 1 - 2^-K_SHIFT.
- ACC_W, DATA_W+K_SHIFT+3, width of the signed fixed-point accumulator (K_SHIFT fractional bits).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- io_clear  input  1  synchronous clear of filter history.
- io_mute  input  1  soft-mute request (used only with AUDIO_SOFT_MUTE_EN).
- io_in_valid  input  1  io_in_data holds a sample.
- io_in_ready  output  1  block accepts a sample this cycle.
- io_in_data  input  DATA_W  signed sample from the mixer.
- io_out_valid  output  1  io_out_data holds a filtered sample.
- io_out_ready  input  1  consumer accepts io_out_data.
- io_out_data  output  DATA_W  filtered, saturated signed sample.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; acc=0, x_prev=0, x_reg=0, out_reg=0.
  - io_in_ready=1, io_out_valid=0, io_out_data=0.
  - Mute gain = 2^8 (unity).
- State IDLE:
  - io_in_ready=1.
  - On io_in_valid: x_reg<=io_in_data, go to CALC.
- State CALC:
  - io_in_ready=0.
  - diff = x_reg - x_prev, DATA_W+1 bits signed.
  - acc <= acc + (diff <<< K_SHIFT) - (acc >>> K_SHIFT), arithmetic shift, ACC_W bits, no wrap for any legal input.
  - x_prev <= x_reg.
  - y = acc_new >>> K_SHIFT, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_reg <= y. Go to OUT.
- State OUT:
  - io_out_valid=1, io_out_data=out_reg, held stable until io_out_ready.
  - On io_out_ready: go to IDLE.
  - io_in_ready stays 0, so there is no simultaneous accept/emit.
- Timing:
  - Latency: sample accepted in cycle N gives io_out_valid in cycle N+2.
  - Maximum throughput: one sample per 3 cycles.
- io_clear (priority over all else except reset):
  - acc, x_prev, out_reg <= 0; state <= IDLE; io_out_valid drops next cycle.
  - Any in-flight sample is discarded.
  - Mute gain is not affected.
- io_out_data is registered (out_reg); no combinational path from inputs to outputs except io_in_ready from state.
- io_in_data changes while io_in_valid is low are ignored. A sample accepted in IDLE is latched once; later io_in_data changes do not affect it.

Optional Feature:
- Macro: AUDIO_SOFT_MUTE_EN.
- With the macro defined:
  - 9-bit gain register g in 0..256, reset value 256.
  - Each time CALC executes, g decrements by 1 (floor 0) if io_mute=1, else increments by 1 (ceiling 256).
  - out_reg <= sat((y_sat * g_new) >>> 8), where g_new is the updated gain.
  - g=256 is bit-exact pass-through. Full ramp takes 256 samples each way, so there are no clicks.
- Without the macro:
  - io_mute is ignored and out_reg = y_sat.
  - No gain logic is synthesised.

Test Plan:
- Step: after reset, feed constant 1000 with io_out_ready=1 → outputs 1000, 996, 992 …, decaying monotonically toward 0, each output 2 cycles after acceptance.
- Saturation: after reset feed -32768 then 32767 → outputs -32768 then 32767 (internal 32895 clamped).
- Backpressure: hold io_out_ready=0 for 10 cycles in OUT → io_out_valid and io_out_data stable, io_in_ready=0, input samples not consumed. Release → exactly one handshake, then IDLE.
- Clear mid-operation: pulse io_clear during CALC and during OUT → io_out_valid=0 the next cycle. Next input 500 yields output 500 (history zeroed).
- Async reset: assert reset_n low mid-OUT between clock edges → io_out_valid=0, io_out_data=0, io_in_ready=1 immediately, without waiting for a clock edge.
- (AUDIO_SOFT_MUTE_EN) Constant input 1000 with filter settled: raise io_mute → output ramps to 0 after 256 samples. Drop io_mute → ramps back, reaching unity (g=256) after 256 samples.

Source files
------------

// File: rtl/audio_dc_filter.sv
// DC-blocking first-order high-pass for the mixer output: y = x - x_prev + (1 - 2^-K_SHIFT) * y_prev.
// Define AUDIO_SOFT_MUTE_EN to add a 256-step soft-mute gain ramp driven by io_mute.
module audio_dc_filter #(
  parameter int DATA_W  = 16,
  parameter int K_SHIFT = 8,
  parameter int ACC_W   = DATA_W + K_SHIFT + 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_clear,
  input  logic              io_mute,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic signed [DATA_W-1:0] x_prev_q, x_prev_d;
  logic signed [DATA_W-1:0] out_q, out_d;

  logic signed [DATA_W:0]    diff;
  logic signed [ACC_W-1:0]   diff_ext;
  logic signed [ACC_W-1:0]   acc_calc;
  logic signed [ACC_W-1:0]   y_wide;
  logic [ACC_W-DATA_W:0]     y_top;
  logic signed [DATA_W-1:0]  y_sat;
  logic signed [DATA_W-1:0]  out_calc;

  assign diff     = {x_q[DATA_W-1], x_q} - {x_prev_q[DATA_W-1], x_prev_q};
  assign diff_ext = {{(ACC_W-DATA_W-1){diff[DATA_W]}}, diff};
  assign acc_calc = acc_q + (diff_ext <<< K_SHIFT) - (acc_q >>> K_SHIFT);
  assign y_wide   = acc_calc >>> K_SHIFT;
  assign y_top    = y_wide[ACC_W-1:DATA_W-1];

  // The result fits in DATA_W bits only when every bit above the sign bit copies it.
  always_comb begin
    y_sat = y_wide[DATA_W-1:0];
    if (!(&y_top || ~|y_top)) begin
      y_sat = y_wide[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

`ifdef AUDIO_SOFT_MUTE_EN
  logic [8:0]               gain_q, gain_d;
  logic signed [DATA_W+9:0] gain_y_ext;
  logic signed [DATA_W+9:0] gain_g_ext;
  logic signed [DATA_W+9:0] gain_prod;
  logic signed [DATA_W+9:0] gain_scaled;
  logic [10:0]              gain_top;

  always_comb begin
    gain_d = gain_q;
    if (state_q == ST_CALC && !io_clear) begin
      if (io_mute) begin
        gain_d = (gain_q == 9'd0) ? 9'd0 : gain_q - 9'd1;
      end else begin
        gain_d = (gain_q == 9'd256) ? 9'd256 : gain_q + 9'd1;
      end
    end
  end

  assign gain_y_ext  = {{10{y_sat[DATA_W-1]}}, y_sat};
  assign gain_g_ext  = {{(DATA_W+1){1'b0}}, gain_d};
  assign gain_prod   = gain_y_ext * gain_g_ext;
  assign gain_scaled = gain_prod >>> 8;
  assign gain_top    = gain_scaled[DATA_W+9:DATA_W-1];

  always_comb begin
    out_calc = gain_scaled[DATA_W-1:0];
    if (!(&gain_top || ~|gain_top)) begin
      out_calc = gain_scaled[DATA_W+9] ? SAT_MIN : SAT_MAX;
    end
  end

  // Gain survives io_clear so a mute in progress is not undone by a history flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gain_q <= 9'd256;
    end else begin
      gain_q <= gain_d;
    end
  end
`else
  logic mute_unused;
  assign mute_unused = io_mute;
  assign out_calc    = y_sat;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    x_d      = x_q;
    x_prev_d = x_prev_q;
    out_d    = out_q;
    case (state_q)
      ST_IDLE: begin
        if (io_in_valid) begin
          x_d     = io_in_data;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = acc_calc;
        x_prev_d = x_q;
        out_d    = out_calc;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (io_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (io_clear) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      x_prev_d = '0;
      out_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      x_q      <= '0;
      x_prev_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      x_prev_q <= x_prev_d;
      out_q    <= out_d;
    end
  end

  assign io_in_ready  = (state_q == ST_IDLE);
  assign io_out_valid = (state_q == ST_OUT);
  assign io_out_data  = out_q;

endmodule

// File: tb/tb_audio_dc_filter.sv
// Self-checking bench for audio_dc_filter: vector table, model-driven scoreboard and corner-case sequences.
// Also models the soft-mute gain when AUDIO_SOFT_MUTE_EN is defined.
module tb_audio_dc_filter;

  logic        clk;
  logic        reset_n;
  logic        io_clear;
  logic        io_mute;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [15:0] io_in_data;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [15:0] io_out_data;

  audio_dc_filter dut (
    .clock        (clk),
    .reset_n      (reset_n),
    .io_clear     (io_clear),
    .io_mute      (io_mute),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_data   (io_in_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_data  (io_out_data)
  );

  typedef struct {
    int data;
    int acc_cyc;
  } exp_t;

  typedef struct {
    bit rst;
    int x;
    int exp_y;
  } vec_t;

  exp_t   sbq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     txn = 0;
  bit     seen = 0;
  longint m_acc = 0;
  int     m_xp = 0;
  int     m_gain = 256;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic model_step(input int x, input bit mute, output int y);
    longint d;
    longint yw;
    d     = longint'(x) - longint'(m_xp);
    m_acc = m_acc + d * 256 - (m_acc >>> 8);
    m_xp  = x;
    yw    = m_acc >>> 8;
    y     = clamp16(yw);
`ifdef AUDIO_SOFT_MUTE_EN
    if (mute) m_gain = (m_gain > 0) ? m_gain - 1 : 0;
    else      m_gain = (m_gain < 256) ? m_gain + 1 : 256;
    yw = (longint'(y) * longint'(m_gain)) >>> 8;
    y  = clamp16(yw);
`else
    if (mute) y = y;
`endif
  endtask

  // Output monitor: latency on first sight of valid, data on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      seen = 0;
    end else if (io_out_valid) begin
      if (!seen) begin
        seen = 1;
        if (sbq.size() != 0) chk("latency", cyc - sbq[0].acc_cyc, 2);
      end
      if (io_out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", int'($signed(io_out_data)), 99999);
        end else begin
          e = sbq.pop_front();
          txn++;
          $display("txn %0d: out=%0d exp=%0d", txn, int'($signed(io_out_data)), e.data);
          chk("out_data", int'($signed(io_out_data)), e.data);
        end
        seen = 0;
      end
    end else begin
      seen = 0;
    end
  end

  task automatic model_clear();
    m_acc = 0;
    m_xp  = 0;
    sbq.delete();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #3;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    m_gain = 256;
  endtask

  task automatic send(input int x, input bit mute, input bit use_exp, input int exp_v);
    int  y;
    int  xv;
    bit  got;
    got         = 0;
    xv          = x;
    io_in_data  = xv[15:0];
    io_in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (io_in_ready) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      io_in_valid = 1'b0;
      return;
    end
    io_mute = mute;
    model_step(x, mute, y);
    if (use_exp) y = exp_v;
    sbq.push_back('{data: y, acc_cyc: cyc});
    @(posedge clk);
    #1;
    io_in_valid = 1'b0;
    io_in_data  = 16'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (io_out_valid) got = 1;
    end
    if (!got) chk(name, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    int   exp_hold;
    tbl[0] = '{rst: 1'b1, x: 1000,   exp_y: 1000};
    tbl[1] = '{rst: 1'b0, x: 1000,   exp_y: 996};
    tbl[2] = '{rst: 1'b0, x: 1000,   exp_y: 992};
    tbl[3] = '{rst: 1'b0, x: 1000,   exp_y: 988};
    tbl[4] = '{rst: 1'b0, x: 0,      exp_y: -16};
    tbl[5] = '{rst: 1'b0, x: 0,      exp_y: -16};
    tbl[6] = '{rst: 1'b1, x: -32768, exp_y: -32768};
    tbl[7] = '{rst: 1'b0, x: 32767,  exp_y: 32767};

    reset_n      = 1'b0;
    io_clear     = 1'b0;
    io_mute      = 1'b0;
    io_in_valid  = 1'b0;
    io_in_data   = 16'd0;
    io_out_ready = 1'b1;
    #1;
    chk("reset_in_ready", int'(io_in_ready), 1);
    chk("reset_out_valid", int'(io_out_valid), 0);
    chk("reset_out_data", int'($signed(io_out_data)), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Step response and saturation from the vector table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst) begin
        wait_idle();
        apply_reset();
      end
      send(tbl[i].x, 1'b0, 1'b1, tbl[i].exp_y);
    end
    wait_idle();

    // Backpressure: output held, input refused, exactly one handshake on release
    io_out_ready = 1'b0;
    send(1234, 1'b0, 1'b0, 0);
    wait_valid("bp_valid_timeout");
    exp_hold = (sbq.size() != 0) ? sbq[0].data : 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      io_in_valid = 1'b1;
      io_in_data  = 16'd777;
      @(negedge clk);
      chk("bp_out_valid", int'(io_out_valid), 1);
      chk("bp_out_data", int'($signed(io_out_data)), exp_hold);
      chk("bp_in_ready", int'(io_in_ready), 0);
    end
    @(posedge clk);
    #1;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", int'(io_out_valid), 0);
    chk("bp_release_ready", int'(io_in_ready), 1);
    chk("bp_queue_empty", sbq.size(), 0);

    // Clear while in CALC
    send(3000, 1'b0, 1'b0, 0);
    io_clear = 1'b1;
    @(posedge clk);
    #1;
    io_clear = 1'b0;
    chk("clr_calc_valid", int'(io_out_valid), 0);
    chk("clr_calc_data", int'($signed(io_out_data)), 0);
    model_clear();
    send(500, 1'b0, 1'b0, 0);
    wait_idle();

    // Clear while in OUT
    io_out_ready = 1'b0;
    send(-2000, 1'b0, 1'b0, 0);
    wait_valid("clr_out_valid_timeout");
    @(posedge clk);
    #1;
    io_clear = 1'b1;
    @(posedge clk);
    #1;
    io_clear = 1'b0;
    chk("clr_out_valid", int'(io_out_valid), 0);
    chk("clr_out_data", int'($signed(io_out_data)), 0);
    chk("clr_out_ready", int'(io_in_ready), 1);
    model_clear();
    io_out_ready = 1'b1;
    send(500, 1'b0, 1'b0, 0);
    wait_idle();

    // Random full-range samples with random mute requests
    for (int i = 0; i < 24; i++) begin
      send(int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)), 1'b0, 0);
    end
    wait_idle();

`ifdef AUDIO_SOFT_MUTE_EN
    // Full mute ramp down and back up on a large alternating signal
    for (int i = 0; i < 520; i++) begin
      send((i % 2 == 0) ? 8000 : -8000, (i < 260), 1'b0, 0);
    end
    wait_idle();
`endif

    // Async reset between clock edges while holding a sample in OUT
    io_mute      = 1'b0;
    io_out_ready = 1'b0;
    send(500, 1'b0, 1'b0, 0);
    wait_valid("ar_valid_timeout");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(io_out_valid), 0);
    chk("async_rst_data", int'($signed(io_out_data)), 0);
    chk("async_rst_ready", int'(io_in_ready), 1);
    model_clear();
    m_gain = 256;
    @(posedge clk);
    #1;
    reset_n      = 1'b1;
    io_out_ready = 1'b1;
    send(500, 1'b0, 1'b1, 500);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
